dmem_mmio: RTL
==============

Name: dmem_mmio

Overview:
- Data-side memory stage directly downstream of the single-cycle MIPS core.
- Consumes the core's memwrite, aluout (address) and writedata; returns readdata in the same cycle.
- Contains word-addressed data RAM plus a small MMIO page: free-running timer, 8-bit TX FIFO with valid/ready drain port, and an LED register.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of 2.
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, 2..16.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- memwrite  input  1  store strobe from core
- addr  input  32  byte address (core aluout)
- writedata  input  32  store data
- readdata  output  32  load data, combinational from addr
- tx_valid  output  1  FIFO head valid
- tx_data  output  8  FIFO head byte
- tx_ready  input  1  sink accepts head when high with tx_valid
- leds  output  8  LED register

Behaviour:
- Decode: addr[31:16]==16'hFFFF selects MMIO; all other addresses select RAM. addr[1:0] is ignored everywhere (no misalignment trap).
- RAM:
  - Word index addr[log2(RAM_WORDS)+1:2]; upper bits ignored, so out-of-range addresses alias modulo RAM_WORDS.
  - Asynchronous read; write on clk when memwrite and RAM selected.
  - Contents are not cleared by reset.
- MMIO offsets (addr[15:0]); readdata for any other MMIO offset = 0, writes to it have no effect:
  - 0x0 TIMER: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0. A write loads writedata; the write wins over the increment, and counting resumes the next cycle.
  - 0x4 TXDATA: a write pushes writedata[7:0]; reads return 0.
  - 0x8 STATUS: bit0 empty, bit1 full, bit3 overflow (sticky), bits[12:8] count, all other bits 0. Writing with writedata[3]=1 clears overflow.
  - 0xC LEDS: write loads writedata[7:0]; reads return {24'b0, leds}.
- TX FIFO:
  - Circular buffer with read/write pointers and count.
  - tx_valid = (count!=0); tx_data = head entry.
  - Pop when tx_valid && tx_ready.
  - A push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle (full + push + pop -> count unchanged, both accepted).
  - A push while full with no pop is dropped: overflow set, contents and count unchanged.
  - No bypass: a pushed byte is first visible on tx_data the cycle after the push.
  - Pointers wrap at FIFO_DEPTH.
  - Data on tx_data is stable while tx_valid && !tx_ready.
- Simultaneous overflow-clear write and dropped push cannot occur (one store per cycle).
- Reset (any cycle, including mid-drain):
  - TIMER=0, count=0, pointers=0, overflow=0, leds=0, hence tx_valid=0.
  - A store presented in the reset cycle to an MMIO register is ignored.
  - A store presented in the reset cycle to RAM is performed.
  - readdata remains a pure function of addr and current state.
- Latency: loads 0 cycles (combinational); stores and register updates take effect at the next rising edge.

Test Plan:
- RAM: store 0xDEADBEEF to 0x0000_0010 -> load 0x10 returns 0xDEADBEEF; load 0x0000_0110 (RAM_WORDS=64) aliases -> 0xDEADBEEF; load 0x13 -> same word.
- TIMER: release reset, read 0xFFFF_0000 after 5 cycles -> 5; write 0xFFFFFFFE -> reads 0xFFFFFFFE, 0xFFFFFFFF, then 0x0 on following cycles.
- FIFO fill/overflow: tx_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> STATUS=0x0000_0402 (count 4, full) then 0x0000_040A (overflow); drain yields 0x11..0x44 only, 0x55 lost; write STATUS 0x8 -> overflow clears.
- Handshake: push 0xA5 with tx_ready=1 -> tx_valid rises the cycle after the push with tx_data=0xA5, pops that cycle, tx_valid low the next cycle; STATUS ends at 0x0000_0001.
- Full + simultaneous push/pop: FIFO full, tx_ready=1, push 0x99 -> head advances, count stays 4, overflow stays 0, 0x99 emerges last.
- Reset mid-operation: FIFO count 3, leds=0x5A, timer running, assert reset one cycle -> tx_valid=0, leds=0, TIMER reads 0 then counts from 1; RAM word previously written still reads back unchanged.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data-side memory stage for the single-cycle MIPS core: word RAM plus an MMIO page
// holding a free-running timer, a byte-wide TX FIFO with valid/ready drain, and LEDs.
module dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [7:0]  leds
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic          mmio_sel;
    logic [13:0]   reg_sel;
    logic [AW-1:0] ram_idx;
    logic          wr_ram, wr_timer, wr_txdata, wr_status, wr_leds;
    logic [1:0]    unused_addr_lsbs;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic [31:0]   timer_q, timer_d;
    logic [7:0]    leds_q, leds_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          pop, push_ok, fifo_full;
    logic [31:0]   status;

    // Byte lane is irrelevant: every access is treated as a full word.
    assign unused_addr_lsbs = addr[1:0];

    assign mmio_sel  = (addr[31:16] == 16'hFFFF);
    assign reg_sel   = addr[15:2];
    assign ram_idx   = addr[AW+1:2];

    assign wr_ram    = memwrite && !mmio_sel;
    assign wr_timer  = memwrite && mmio_sel && (reg_sel == 14'd0);
    assign wr_txdata = memwrite && mmio_sel && (reg_sel == 14'd1);
    assign wr_status = memwrite && mmio_sel && (reg_sel == 14'd2);
    assign wr_leds   = memwrite && mmio_sel && (reg_sel == 14'd3);

    // RAM is not reset, so a store landing in a reset cycle still goes through.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram_q[ram_idx] <= writedata;
        end
    end

    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign tx_valid  = (count_q != '0);
    assign tx_data   = fifo_q[rd_ptr_q];
    assign leds      = leds_q;
    assign pop       = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok   = wr_txdata && (!fifo_full || pop);

    always_comb begin
        timer_d  = timer_q + 32'd1;
        leds_d   = leds_q;
        ovf_d    = ovf_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (wr_timer) begin
            timer_d = writedata;
        end
        if (wr_leds) begin
            leds_d = writedata[7:0];
        end
        if (wr_status && writedata[3]) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q  <= '0;
            leds_q   <= '0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            timer_q  <= timer_d;
            leds_q   <= leds_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            fifo_q[wr_ptr_q] <= writedata[7:0];
        end
    end

    assign status = {19'b0, 5'(count_q), 4'b0, ovf_q, 1'b0, fifo_full, !tx_valid};

    always_comb begin
        readdata = '0;
        if (mmio_sel) begin
            case (reg_sel)
                14'd0:   readdata = timer_q;
                14'd2:   readdata = status;
                14'd3:   readdata = {24'b0, leds_q};
                default: readdata = '0;
            endcase
        end else begin
            readdata = ram_q[ram_idx];
        end
    end

endmodule
